// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants, result payload and syndrome helper.
package hamming_pkg;

    localparam int unsigned CW_LEN = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    localparam int unsigned PAR_POS  [SYN_W]  = '{1, 2, 4};
    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7};

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syndrome;
        logic              err;
    } hamming_result_t;

    // Syndrome bit b covers every position whose index has parity position b's bit set.
    function automatic logic [SYN_W-1:0] hamming_syndrome(logic [CW_LEN:1] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int unsigned b = 0; b < SYN_W; b++) begin
            for (int unsigned i = 1; i <= CW_LEN; i++) begin
                if ((i & PAR_POS[b]) != 0) begin
                    s[b] = s[b] ^ cw[i];
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector: codeword in, syndrome and data out.
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [CW_LEN:1]   cw,
    output logic [SYN_W-1:0]  syndrome_c,
    output logic [DATA_W-1:0] data_c
);

    logic [CW_LEN:1] fixed;

    always_comb begin
        syndrome_c = hamming_syndrome(cw);
        fixed      = cw;
        data_c     = '0;
        if (syndrome_c != '0) begin
            fixed[syndrome_c] = ~fixed[syndrome_c];
        end
        // MSB of the data word is the lowest data position (c3).
        for (int unsigned i = 0; i < DATA_W; i++) begin
            data_c[DATA_W-1-i] = fixed[DATA_POS[i]];
        end
    end

endmodule

// File: rtl/hamming74_decode_s.sv
// Serial Hamming(7,4) receiver: assembles 7-bit frames from a strobed bit stream,
// corrects single-bit errors and reports status, with a mid-frame idle timeout.
module hamming74_decode_s
    import hamming_pkg::*;
#(
    parameter int unsigned IDLE_TO = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_in,
    input  logic              strobe_in,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome,
    output logic              err_flag,
    output logic              valid_out,
    output logic              frame_drop,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned IDLE_W = $clog2(IDLE_TO + 1);
    localparam int unsigned BCNT_W = 3;

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t            state_q, state_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW_LEN:1]   shift_q, shift_d;
    logic [CW_LEN:1]   hold_q, hold_d;
    logic              pend_q, pend_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    hamming_result_t   res_q, res_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              last_bit_c;
    logic              timeout_c;
    logic [SYN_W-1:0]  hold_syn_c;
    logic [DATA_W-1:0] hold_data_c;

    assign last_bit_c = strobe_in && (bit_cnt_q == BCNT_W'(CW_LEN - 1));
    // An accepted bit always wins over a timeout on the same cycle.
    assign timeout_c  = (state_q == S_RECV) && !strobe_in &&
                        (idle_q == IDLE_W'(IDLE_TO - 1));

    hamming74_correct u_correct (
        .cw         (hold_q),
        .syndrome_c (hold_syn_c),
        .data_c     (hold_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (strobe_in) state_d = S_RECV;
            S_RECV: if (last_bit_c || timeout_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        pend_d    = 1'b0;
        idle_d    = idle_q;
        res_d     = res_q;
        valid_d   = pend_q;
        drop_d    = 1'b0;
        err_cnt_d = err_cnt_q;

        if (strobe_in) begin
            idle_d = '0;
            if (last_bit_c) begin
                hold_d    = {d_in, shift_q[CW_LEN-1:1]};
                shift_d   = '0;
                bit_cnt_d = '0;
                pend_d    = 1'b1;
            end else begin
                shift_d[BCNT_W'(bit_cnt_q + BCNT_W'(1))] = d_in;
                bit_cnt_d = BCNT_W'(bit_cnt_q + BCNT_W'(1));
            end
        end else if (state_q == S_RECV) begin
            if (timeout_c) begin
                idle_d    = '0;
                shift_d   = '0;
                bit_cnt_d = '0;
                drop_d    = 1'b1;
            end else begin
                idle_d = IDLE_W'(idle_q + IDLE_W'(1));
            end
        end else begin
            idle_d = '0;
        end

        // Frame completed last cycle: publish the corrected result.
        if (pend_q) begin
            res_d.data     = hold_data_c;
            res_d.syndrome = hold_syn_c;
            res_d.err      = (hold_syn_c != '0);
            if ((hold_syn_c != '0) && (err_cnt_q != '1)) begin
                err_cnt_d = CNT_W'(err_cnt_q + CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            idle_q    <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            idle_q    <= idle_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_out   = res_q.data;
    assign syndrome   = res_q.syndrome;
    assign err_flag   = res_q.err;
    assign valid_out  = valid_q;
    assign frame_drop = drop_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_hamming74_decode_s.sv
// Directed bench for hamming74_decode_s: vector table of frames plus timeout and reset sequences.
module tb_hamming74_decode_s;

    logic clk = 1'b0;
    logic rst_n, d_in, strobe_in;

    logic [3:0] data_a, data_b;
    logic [2:0] syn_a, syn_b;
    logic       err_a, err_b, valid_a, valid_b, drop_a, drop_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    hamming74_decode_s #(.IDLE_TO(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .strobe_in(strobe_in),
        .data_out(data_a), .syndrome(syn_a), .err_flag(err_a),
        .valid_out(valid_a), .frame_drop(drop_a), .err_count(cnt_a)
    );

    hamming74_decode_s #(.IDLE_TO(16), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .strobe_in(strobe_in),
        .data_out(data_b), .syndrome(syn_b), .err_flag(err_b),
        .valid_out(valid_b), .frame_drop(drop_b), .err_count(cnt_b)
    );

    typedef struct {
        logic [7:1] cw;
        int         flip1;
        int         flip2;
        int         gap;
        logic [3:0] exp_data;
        logic [2:0] exp_syn;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
        logic [7:0] c8;
        logic [1:0] c2;
    } res_t;

    localparam logic [7:1] CW_1011 = 7'b1100110;
    localparam logic [7:1] CW_0110 = 7'b0110011;

    res_t got_q[$];
    res_t exp_q[$];
    vec_t vecs[15];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_drop = 0;
    int   n_drop_b = 0;
    int   exp_c8 = 0;
    int   exp_c2 = 0;

    always @(negedge clk) begin
        if (valid_a) got_q.push_back('{data_a, syn_a, err_a, cnt_a, cnt_b});
        if (drop_a) n_drop++;
        if (drop_b) n_drop_b++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put_bit(input logic b);
        d_in      = b;
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
    endtask

    task automatic idle(input int n);
        strobe_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [3:0] data, input logic [2:0] syn);
        if (syn != 3'd0) begin
            if (exp_c8 < 255) exp_c8++;
            if (exp_c2 < 3) exp_c2++;
        end
        exp_q.push_back('{data, syn, (syn != 3'd0), 8'(exp_c8), 2'(exp_c2)});
    endtask

    task automatic send_vec(input vec_t v);
        logic [7:1] tx;
        tx = v.cw;
        if (v.flip1 != 0) tx[v.flip1] = ~tx[v.flip1];
        if (v.flip2 != 0) tx[v.flip2] = ~tx[v.flip2];
        for (int i = 1; i <= 7; i++) begin
            put_bit(tx[i]);
            if (v.gap > 0) idle(v.gap);
        end
        expect_frame(v.exp_data, v.exp_syn);
    endtask

    task automatic drain_and_check(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s_frames", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s[%0d]_data", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
                chk($sformatf("%s[%0d]_syn", tag, i), 32'(got_q[i].syn), 32'(exp_q[i].syn));
                chk($sformatf("%s[%0d]_err", tag, i), 32'(got_q[i].err), 32'(exp_q[i].err));
                chk($sformatf("%s[%0d]_cnt8", tag, i), 32'(got_q[i].c8), 32'(exp_q[i].c8));
                chk($sformatf("%s[%0d]_cnt2", tag, i), 32'(got_q[i].c2), 32'(exp_q[i].c2));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, 32'(data_a), 32'd0);
        chk({tag, "_syn"}, 32'(syn_a), 32'd0);
        chk({tag, "_err"}, 32'(err_a), 32'd0);
        chk({tag, "_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_drop"}, 32'(drop_a), 32'd0);
        chk({tag, "_cnt8"}, 32'(cnt_a), 32'd0);
        chk({tag, "_cnt2"}, 32'(cnt_b), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{CW_1011,   0, 0, 0, 4'b1011, 3'd0};
        vecs[1]  = '{CW_1011,   5, 0, 0, 4'b1011, 3'd5};
        vecs[2]  = '{CW_1011,   1, 0, 0, 4'b1011, 3'd1};
        for (int p = 0; p < 8; p++) begin
            vecs[3+p] = '{CW_1011, p, 0, p % 4, 4'b1011, 3'(p)};
        end
        vecs[11] = '{7'b0000000, 0, 0, 1, 4'b0000, 3'd0};
        vecs[12] = '{7'b1111111, 7, 0, 0, 4'b1111, 3'd7};
        vecs[13] = '{CW_0110,   3, 0, 2, 4'b0110, 3'd3};
        vecs[14] = '{CW_1011,   1, 2, 0, 4'b0011, 3'd3};

        // Reset with strobe active: nothing may be captured.
        rst_n = 1'b0; d_in = 1'b1; strobe_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1; strobe_in = 1'b0; d_in = 1'b0;
        idle(2);

        for (int i = 0; i < 15; i++) send_vec(vecs[i]);
        drain_and_check("table");
        chk("no_drop_in_table", 32'(n_drop), 32'd0);
        chk("sat_cnt2", 32'(cnt_b), 32'd3);
        chk("total_cnt8", 32'(cnt_a), 32'd12);

        // Timeout: 4 bits, then strobe low; drop fires on the 16th idle cycle only.
        for (int i = 1; i <= 4; i++) put_bit(CW_1011[i]);
        idle(15);
        @(negedge clk);
        chk("drop_before_to", 32'(n_drop), 32'd0);
        idle(1);
        @(negedge clk);
        #1;
        chk("drop_at_to", 32'(n_drop), 32'd1);
        chk("drop_at_to_sat", 32'(n_drop_b), 32'd1);
        chk("drop_no_valid", 32'(got_q.size()), 32'd0);
        chk("drop_hold_data", 32'(data_a), 32'(4'b0011));
        chk("drop_hold_syn", 32'(syn_a), 32'd3);
        chk("drop_hold_cnt", 32'(cnt_a), 32'd12);
        idle(1);
        send_vec(vecs[0]);
        drain_and_check("after_to");
        chk("drop_single", 32'(n_drop), 32'd1);

        // Reset mid-frame, then a clean frame decodes normally.
        for (int i = 1; i <= 3; i++) put_bit(CW_1011[i]);
        rst_n = 1'b0;
        idle(2);
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        exp_c8 = 0; exp_c2 = 0;
        send_vec(vecs[0]);
        drain_and_check("after_rst");

        // Reset right after the 7th bit suppresses the pending valid.
        for (int i = 1; i <= 7; i++) put_bit(CW_1011[i]);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("pend_suppressed", 32'(got_q.size()), 32'd0);
        chk("pend_cnt", 32'(cnt_a), 32'd0);
        got_q.delete();

        // Counting restarts from zero and saturates again.
        for (int i = 0; i < 5; i++) send_vec('{CW_1011, 6, 0, 0, 4'b1011, 3'd6});
        drain_and_check("resat");
        chk("resat_cnt2", 32'(cnt_b), 32'd3);
        chk("resat_cnt8", 32'(cnt_a), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming74_decode_s.md
# hamming74_decode_s

Serial Hamming(7,4) receiver and single-error corrector. It sits downstream of the serial error-injection stage and consumes the same `d_in`/`strobe_in` bit stream, where codeword position `error_pos` (1..7) may have been flipped and 0 means no flip. It assembles 7-bit frames, computes the syndrome, corrects any single-bit error and presents the 4 data bits in parallel with status.

## Interface
- `IDLE_TO`, default 16: consecutive cycles with `strobe_in` low mid-frame before the partial frame is dropped; must be at least 2.
- `CNT_W`, default 8: width of the saturating error counter.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; release is synchronous to `clk`.
- `d_in`  in  1  serial codeword bit; sampled only when `strobe_in`=1.
- `strobe_in`  in  1  bit-valid qualifier; one bit is accepted per `clk` edge with `strobe_in`=1.
- `data_out`  out  4  corrected data {c3,c5,c6,c7}, MSB = c3.
- `syndrome`  out  3  {s4,s2,s1}; equals the erroneous position, 0 = clean.
- `err_flag`  out  1  1 when the frame's syndrome ≠ 0.
- `valid_out`  out  1  one-cycle pulse: `data_out`/`syndrome`/`err_flag` updated.
- `frame_drop`  out  1  one-cycle pulse: partial frame discarded on timeout.
- `err_count`  out  CNT_W  frames with nonzero syndrome; saturates at all-ones.

## Operation
- Bit order: first accepted bit is codeword position c1, then c2 … c7. Parity is at c1, c2 and c4; data is at c3, c5, c6 and c7.
- Syndrome:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
- Correction: if syndrome = k ≠ 0, invert c_k before extracting data. A flip of c1, c2 or c4 leaves `data_out` unchanged but still sets `err_flag`.
- The block has no double-error detection. A 2-bit error is miscorrected silently; this is the defined behaviour.
- FSM has two states:
  - IDLE (bit count 0): the first accepted bit moves to RECV with count 1.
  - RECV (count 1..6): each accepted bit increments the count. The 7th accepted bit completes the frame, latches the full codeword into a hold register, clears the count and returns to IDLE.
  - Timeout: in RECV, an idle counter increments on every cycle with `strobe_in`=0 and clears on every accepted bit. When it reaches `IDLE_TO`, go to IDLE, clear the shift register, pulse `frame_drop`, and leave outputs and `err_count` unchanged.
  - The idle counter is held at 0 while in IDLE.
- Frames may be back-to-back: a bit accepted on the edge after the 7th is c1 of the next frame. No gap is required.
- `err_count` increments once per completed frame with syndrome ≠ 0 and holds at 2^CNT_W−1.

## Timing
- The 7th bit is sampled at edge E. At edge E+1, `data_out`, `syndrome` and `err_flag` update and `valid_out` rises. `valid_out` falls at E+2. Latency is one cycle.
- `err_count` updates at E+1, together with `valid_out`.
- `data_out`, `syndrome` and `err_flag` hold their values until the next `valid_out`.
- `frame_drop` rises at the edge where the idle counter reaches `IDLE_TO` and lasts one cycle.
- If a 7th bit and a timeout would coincide, the accepted bit wins: the idle counter clears, so a timeout cannot fire on a strobe cycle.
- Reset while `rst_n`=0:
  - all outputs are 0;
  - state is IDLE with count 0;
  - shift register, hold register and idle counter are 0;
  - any partial frame is lost.
- Reset asserted mid-frame or in the cycle of a pending `valid_out` suppresses that pulse.
- No bit is accepted on the first edge while `rst_n`=0.

## Structure
- Package `hamming_pkg`:
  - localparams for codeword length (7), data width (4) and parity positions (1, 2, 4);
  - the data-position list {3,5,6,7};
  - a function `hamming_syndrome(logic [7:1] cw)` returning 3 bits.
- Sub-module `hamming74_correct` (combinational) takes the codeword and returns syndrome and corrected data. It is reusable by a parallel decoder.
- The top level holds the FSM, shift register, idle counter, hold/output registers and error counter.

## Test plan
- Clean frame: data 1011, sent as c1..c7 = 0,1,1,0,0,1,1 with continuous strobe → one `valid_out` pulse, `data_out`=4'b1011, `syndrome`=0, `err_flag`=0, `err_count`=0.
- Data-bit error: the same frame with c5 flipped (0,1,1,0,1,1,1) → `syndrome`=3'b101, `data_out`=4'b1011, `err_flag`=1, `err_count`=1.
- Parity-bit error: the same frame with c1 flipped → `syndrome`=3'b001, `data_out`=4'b1011, `err_flag`=1.
- Sweep and gaps: 8 back-to-back frames of data 1011, each with the error at position 0..7 and strobe gaps of 0–3 cycles → `syndrome` equals the error position (0 for no error) and every `data_out`=4'b1011. No frame may be lost when frames are contiguous.
- Timeout: send 4 bits, then hold `strobe_in` low for 16 cycles → `frame_drop` pulses once and there is no `valid_out`. The following 7-bit clean frame decodes correctly.
- Reset and saturation:
  - assert `rst_n`=0 after 3 bits, release, send a clean frame → exactly one `valid_out` with correct data;
  - with `CNT_W`=2, send 5 errored frames → `err_count` reaches 3 and stays at 3.
